// File: rtl/vga_timing_pkg.sv
// Shared types and default 800x600@72Hz (50 MHz pixel clock) constants for the VGA timing block.
package vga_timing_pkg;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} vga_phase_t;

    localparam int unsigned H_COORD_W = 11;
    localparam int unsigned V_COORD_W = 10;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FRONT  = 56;
    localparam int unsigned DEF_H_SYNC   = 120;
    localparam int unsigned DEF_H_BACK   = 64;
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FRONT  = 37;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_BACK   = 23;

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the generator to the renderer / VGA pins.
// frame_start exists only when VGA_FRAME_STROBE_EN is defined.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic                 h_sync;
    logic                 v_sync;
    logic                 disp_enbl;
    logic [H_COORD_W-1:0] h_coord;
    logic [V_COORD_W-1:0] v_coord;
`ifdef VGA_FRAME_STROBE_EN
    logic                 frame_start;

    modport master (output h_sync, v_sync, disp_enbl, h_coord, v_coord, frame_start);
    modport slave  (input  h_sync, v_sync, disp_enbl, h_coord, v_coord, frame_start);
`else
    modport master (output h_sync, v_sync, disp_enbl, h_coord, v_coord);
    modport slave  (input  h_sync, v_sync, disp_enbl, h_coord, v_coord);
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM, advancing on i_step.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 800,
    parameter int unsigned FRONT  = 56,
    parameter int unsigned SYNC   = 120,
    parameter int unsigned BACK   = 64,
    parameter int unsigned WIDTH  = 11
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_cnt,
    output vga_phase_t       o_phase,
    output logic             o_wrap
);

    localparam int unsigned      TOTAL       = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [WIDTH-1:0] LAST        = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] FRONT_START = WIDTH'(ACTIVE);
    localparam logic [WIDTH-1:0] SYNC_START  = WIDTH'(ACTIVE + FRONT);
    localparam logic [WIDTH-1:0] BACK_START  = WIDTH'(ACTIVE + FRONT + SYNC);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    vga_phase_t       phase_q, phase_d;

    assign o_wrap  = i_step && (cnt_q == LAST);
    assign o_cnt   = cnt_q;
    assign o_phase = phase_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Phase tracks the value the counter is about to take, so both stay in lockstep.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (i_step) begin
            cnt_d = o_wrap ? '0 : cnt_q + WIDTH'(1);
        end
        unique case (phase_q)
            PH_ACTIVE: if (i_step && cnt_d == FRONT_START) phase_d = PH_FRONT;
            PH_FRONT:  if (i_step && cnt_d == SYNC_START)  phase_d = PH_SYNC;
            PH_SYNC:   if (i_step && cnt_d == BACK_START)  phase_d = PH_BACK;
            PH_BACK:   if (o_wrap)                         phase_d = PH_ACTIVE;
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator with registered, mutually aligned outputs.
// Define VGA_FRAME_STROBE_EN to add the one-cycle frame_start pulse at (0,0).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT    = DEF_H_FRONT,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BACK     = DEF_H_BACK,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT    = DEF_V_FRONT,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BACK     = DEF_V_BACK,
    parameter logic        H_SYNC_POL = 1'b1,
    parameter logic        V_SYNC_POL = 1'b1
) (
    input logic          i_clk,
    input logic          i_rst,
    vga_timing_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 2048 || V_TOTAL > 1024 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
        $fatal(1, "vga_timing_gen: timing parameters out of range");
    end

    logic [H_COORD_W-1:0] h_cnt;
    logic [V_COORD_W-1:0] v_cnt;
    vga_phase_t           h_phase, v_phase;
    logic                 h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .WIDTH  (H_COORD_W)
    ) u_h_axis (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_step  (1'b1),
        .o_cnt   (h_cnt),
        .o_phase (h_phase),
        .o_wrap  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .WIDTH  (V_COORD_W)
    ) u_v_axis (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_step  (h_wrap),
        .o_cnt   (v_cnt),
        .o_phase (v_phase),
        .o_wrap  ()
    );

    logic                 h_sync_q, v_sync_q, disp_enbl_q;
    logic [H_COORD_W-1:0] h_coord_q;
    logic [V_COORD_W-1:0] v_coord_q;

    // One register stage for everything keeps sync, enable and coordinates aligned.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_sync_q    <= ~H_SYNC_POL;
            v_sync_q    <= ~V_SYNC_POL;
            disp_enbl_q <= 1'b0;
            h_coord_q   <= '0;
            v_coord_q   <= '0;
        end else begin
            h_sync_q    <= (h_phase == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync_q    <= (v_phase == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            disp_enbl_q <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            h_coord_q   <= h_cnt;
            v_coord_q   <= v_cnt;
        end
    end

    assign vga.h_sync    = h_sync_q;
    assign vga.v_sync    = v_sync_q;
    assign vga.disp_enbl = disp_enbl_q;
    assign vga.h_coord   = h_coord_q;
    assign vga.v_coord   = v_coord_q;

`ifdef VGA_FRAME_STROBE_EN
    logic frame_start_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign vga.frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, inverted sync, tiny raster) checked each
// cycle against a position-based arithmetic model of the raster.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    vga_timing_if vif_def ();
    vga_timing_if vif_neg ();
    vga_timing_if vif_sml ();

    vga_timing_gen dut_def (
        .i_clk (clk),
        .i_rst (rst_a),
        .vga   (vif_def)
    );

    vga_timing_gen #(
        .H_SYNC_POL (1'b0),
        .V_SYNC_POL (1'b0)
    ) dut_neg (
        .i_clk (clk),
        .i_rst (rst_a),
        .vga   (vif_neg)
    );

    // Tiny raster: 15 pixels x 9 lines = 135-cycle frame.
    vga_timing_gen #(
        .H_ACTIVE (8),
        .H_FRONT  (2),
        .H_SYNC   (3),
        .H_BACK   (2),
        .V_ACTIVE (5),
        .V_FRONT  (1),
        .V_SYNC   (2),
        .V_BACK   (1)
    ) dut_sml (
        .i_clk (clk),
        .i_rst (rst_b),
        .vga   (vif_sml)
    );

    localparam int SML_FRAME = 15 * 9;

    int n_checks = 0;
    int n_fail   = 0;
    // Cycles since reset release as shown on the outputs; -1 means outputs show reset values.
    int k_a = -1;
    int k_b = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        assert (obs === 32'(exp))
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_grp(input string name, input int k,
                             input int ha, input int hf, input int hsw, input int hb,
                             input int va, input int vf, input int vsw, input int vb,
                             input logic pol, input logic hs, input logic vs, input logic de,
                             input logic [10:0] h, input logic [9:0] v);
        int ht, vt, eh, ev, ehs, evs, ede;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (k < 0) begin
            eh  = 0;
            ev  = 0;
            ede = 0;
            ehs = int'(!pol);
            evs = int'(!pol);
        end else begin
            eh  = k % ht;
            ev  = (k / ht) % vt;
            ede = (eh < ha && ev < va) ? 1 : 0;
            ehs = (eh >= ha + hf && eh < ha + hf + hsw) ? int'(pol) : int'(!pol);
            evs = (ev >= va + vf && ev < va + vf + vsw) ? int'(pol) : int'(!pol);
        end
        chk({name, ".h_coord"}, 32'(h), eh);
        chk({name, ".v_coord"}, 32'(v), ev);
        chk({name, ".disp_enbl"}, 32'(de), ede);
        chk({name, ".h_sync"}, 32'(hs), ehs);
        chk({name, ".v_sync"}, 32'(vs), evs);
    endtask

    function automatic int exp_fs(input int k, input int frame);
        return (k >= 0 && (k % frame) == 0) ? 1 : 0;
    endfunction

    task automatic check_all();
        check_grp("def", k_a, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1,
                  vif_def.h_sync, vif_def.v_sync, vif_def.disp_enbl,
                  vif_def.h_coord, vif_def.v_coord);
        check_grp("neg", k_a, 800, 56, 120, 64, 600, 37, 6, 23, 1'b0,
                  vif_neg.h_sync, vif_neg.v_sync, vif_neg.disp_enbl,
                  vif_neg.h_coord, vif_neg.v_coord);
        check_grp("sml", k_b, 8, 2, 3, 2, 5, 1, 2, 1, 1'b1,
                  vif_sml.h_sync, vif_sml.v_sync, vif_sml.disp_enbl,
                  vif_sml.h_coord, vif_sml.v_coord);
`ifdef VGA_FRAME_STROBE_EN
        chk("sml.frame_start", 32'(vif_sml.frame_start), exp_fs(k_b, SML_FRAME));
        chk("def.frame_start", 32'(vif_def.frame_start), exp_fs(k_a, 1040 * 666));
`endif
    endtask

    // Advance one clock, update the model from the resets seen at that edge, then check.
    task automatic tick();
        logic ra, rb;
        ra = rst_a;
        rb = rst_b;
        @(posedge clk);
        #1;
        k_a = ra ? -1 : k_a + 1;
        k_b = rb ? -1 : k_b + 1;
        check_all();
    endtask

    initial begin
        int de_cnt, hs_cnt;

        // Reset held for 5 cycles.
        for (int i = 0; i < 5; i++) tick();

        // Release and run one full default line plus one cycle.
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        de_cnt = 0;
        hs_cnt = 0;
        for (int i = 0; i < 1040; i++) begin
            tick();
            if (vif_def.disp_enbl === 1'b1) de_cnt++;
            if (vif_def.h_sync === 1'b1) hs_cnt++;
        end
        chk("line.enbl_cycles", 32'(de_cnt), 800);
        chk("line.hsync_cycles", 32'(hs_cnt), 120);
        tick();
        chk("line.wrap_h", 32'(vif_def.h_coord), 0);
        chk("line.wrap_v", 32'(vif_def.v_coord), 1);

`ifdef VGA_FRAME_STROBE_EN
        begin
            int n_pulse, last_k;
            rst_b = 1'b1;
            tick();
            chk("strobe.in_reset", 32'(vif_sml.frame_start), 0);
            rst_b   = 1'b0;
            n_pulse = 0;
            last_k  = -1;
            for (int i = 0; i < 3 * SML_FRAME; i++) begin
                tick();
                if (vif_sml.frame_start === 1'b1) begin
                    n_pulse++;
                    if (last_k >= 0) chk("strobe.spacing", 32'(k_b - last_k), SML_FRAME);
                    last_k = k_b;
                end
            end
            chk("strobe.count", 32'(n_pulse), 3);
        end
`endif

        // Mid-line reset on the default raster at h=400.
        for (int i = 0; i < 2000 && (k_a % 1040) != 400; i++) tick();
        chk("midreset.h_before", 32'(vif_def.h_coord), 400);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        tick();
        chk("midreset.enbl_after", 32'(vif_def.disp_enbl), 1);

        // Mid-frame reset on the tiny raster at h=4, v=3.
        for (int i = 0; i < 300 && (k_b % SML_FRAME) != 3 * 15 + 4; i++) tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        tick();
        chk("midframe.h_after", 32'(vif_sml.h_coord), 0);

        // Randomised reset pulses of random length against the model.
        for (int i = 0; i < 3000; i++) begin
            if (rst_b) begin
                if ($urandom_range(0, 1) == 0) rst_b = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_b = 1'b1;
            end
            if (rst_a) begin
                if ($urandom_range(0, 2) == 0) rst_a = 1'b0;
            end else if ($urandom_range(0, 699) == 0) begin
                rst_a = 1'b1;
            end
            tick();
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 3 * SML_FRAME; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
